vn_extractor: RTL and testbench
===============================

Name: vn_extractor

Overview:
Conditioning stage directly upstream of vector_buffer. Takes the raw sampled entropy bit stream, optionally decimates it, and applies von Neumann debiasing. It also runs a repetition-count health test. Its output pair bit_out/bit_valid drives vector_buffer input_bit/bit_valid one-to-one.

Parameters:
DECIM, 1, use every DECIM-th accepted raw sample (1 = use all); legal range 1..255
REP_LIMIT, 16, consecutive identical used samples that trip the health test; legal range 2..255
CNT_W, 16, width of emitted_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
raw_bit  input  1  raw noise sample
raw_valid  input  1  raw_bit valid this cycle
enable  input  1  extraction enable
bit_out  output  1  debiased bit, to vector_buffer input_bit
bit_valid  output  1  one-cycle strobe, bit_out valid, to vector_buffer bit_valid
health_fail  output  1  sticky repetition-test failure flag
emitted_count  output  CNT_W  saturating count of bit_valid strobes

Behaviour:
- Reset (sync, highest priority):
  - bit_out=0, bit_valid=0, health_fail=0, emitted_count=0.
  - Decimation counter=0, pair FSM=IDLE, run counter=0, last sample=0.
- Accept: a raw sample is accepted when raw_valid=1, enable=1 and health_fail=0.
- Decimation:
  - Counter increments per accepted sample and wraps at DECIM.
  - A sample is "used" when the counter equals DECIM-1 before the increment.
  - DECIM=1: every accepted sample is used.
- Repetition test (on used samples only):
  - First used sample after reset: run=1.
  - Used sample equal to the last used sample: run=run+1. Different: run=1.
  - When the update makes run==REP_LIMIT, health_fail is set on that same edge and is sticky until reset.
- Pair FSM:
  - IDLE: a used sample is stored as a, then go to HAVE_A.
  - HAVE_A: the next used sample b returns the FSM to IDLE.
  - If a!=b: on that edge bit_out<=a and bit_valid<=1 (pair 01 emits 0, 10 emits 1).
  - If a==b: pair discarded, bit_valid stays 0.
- Latency: bit_valid rises on the clock edge that accepts the second sample of an unequal pair. It is visible in the following cycle and lasts exactly 1 cycle.
- bit_valid is 0 in every other cycle. bit_out holds its last value when bit_valid=0.
- Max output rate: one strobe per two used samples. No back-pressure; the downstream stage must accept every strobe.
- enable low: the FSM is forced to IDLE, discarding a stored half-pair. The decimation counter resets to 0. Run counter and last sample are kept.
- health_fail=1:
  - No samples are accepted, the FSM is held in IDLE, bit_valid is forced 0, and emitted_count freezes.
  - The failing sample never emits: it equals the previous used sample, so if it completes a pair, that pair is equal.
- emitted_count increments with each bit_valid strobe and saturates at all-ones.
- raw_valid gaps of any length stall all state. The pair and run state persist across gaps.

Test Plan:
- DECIM=1, REP_LIMIT=4; samples 0,1 then 1,0 (back-to-back) -> bit_valid strobes 1 cycle after each second sample; bit_out=0 then 1; emitted_count=2.
- Samples 0,0,1,1 -> no bit_valid; emitted_count=0; health_fail=0 (max run 2).
- REP_LIMIT=4; samples 1,1,1,1 then 0,1 -> health_fail=1 on the edge of the 4th sample; no strobes; emitted_count=0. Assert reset -> health_fail=0, and a subsequent 0,1 emits 0.
- DECIM=2; raw samples 0,1,1,0 -> used samples are #2 and #4 (1,0) -> one strobe with bit_out=1.
- Sample 0, enable low for 3 cycles, enable high, samples 1,0 -> stored 0 discarded; single strobe with bit_out=1.
- Sample 0, raw_valid low for 5 cycles, sample 1 -> single strobe with bit_out=0 one cycle later. Also: reset asserted while in HAVE_A -> the next pair starts fresh.

Source files
------------

// File: rtl/vn_extractor.sv
// Optional decimation, von Neumann debiasing and a repetition-count health test on a raw entropy bit stream.
// Latency: bit_valid one cycle after the edge accepting the second sample of an unequal pair; no back-pressure.
// Backpressure: none; downstream must take every strobe. Accepts nothing while disabled or after a health failure.
module vn_extractor #(
    parameter int DECIM     = 1,
    parameter int REP_LIMIT = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_bit,
    input  logic             raw_valid,
    input  logic             enable,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             health_fail,
    output logic [CNT_W-1:0] emitted_count
);

    typedef enum logic {IDLE, HAVE_A} state_t;

    localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);
    localparam logic [7:0] REP_MAX  = 8'(REP_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] dec_cnt;
    logic [7:0] run_cnt;
    logic [7:0] run_d;
    logic       last_smp;
    logic       a_smp;
    logic       accept;
    logic       used;
    logic       emit;
    logic       fail_now;

    always_comb begin
        accept   = raw_valid & enable & ~health_fail;
        used     = accept && (dec_cnt == DEC_LAST);
        run_d    = (raw_bit == last_smp) ? run_cnt + 8'd1 : 8'd1;
        fail_now = used && (run_d == REP_MAX);
        emit     = 1'b0;
        state_d  = state_q;
        if (!enable || health_fail) begin
            state_d = IDLE;
        end else if (used) begin
            if (state_q == IDLE) begin
                state_d = fail_now ? IDLE : HAVE_A;
            end else begin
                state_d = IDLE;
                // A failing sample repeats the stored half, so it can never emit anyway.
                emit    = (raw_bit != a_smp) && !fail_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            dec_cnt       <= 8'd0;
            run_cnt       <= 8'd0;
            last_smp      <= 1'b0;
            a_smp         <= 1'b0;
            bit_out       <= 1'b0;
            bit_valid     <= 1'b0;
            health_fail   <= 1'b0;
            emitted_count <= '0;
        end else begin
            state_q   <= state_d;
            bit_valid <= emit;
            if (emit) begin
                bit_out <= a_smp;
                if (emitted_count != '1)
                    emitted_count <= emitted_count + CNT_W'(1);
            end
            if (!enable)
                dec_cnt <= 8'd0;
            else if (accept)
                dec_cnt <= used ? 8'd0 : dec_cnt + 8'd1;
            // run_cnt starts at 0, so the first used sample lands on 1 whatever last_smp holds.
            if (used) begin
                run_cnt  <= run_d;
                last_smp <= raw_bit;
                if (state_q == IDLE)
                    a_smp <= raw_bit;
            end
            if (fail_now)
                health_fail <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vn_extractor.sv
// Bench for vn_extractor: two instances (DECIM=1/REP=4/CNT_W=16 and DECIM=2/REP=6/CNT_W=3) on shared stimulus,
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_vn_extractor;

    logic clk, reset, raw_bit, raw_valid, enable;
    logic        bo0, bv0, hf0;
    logic [15:0] cnt0;
    logic        bo1, bv1, hf1;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;
    int n_strb0 = 0;
    int n_strb1 = 0;

    int m_decim[2] = '{1, 2};
    int m_lim[2]   = '{4, 6};
    int m_max[2]   = '{65535, 7};
    int m_nacc[2], m_run[2], m_last[2], m_half[2], m_fail[2], m_cnt[2], m_out[2], m_vld[2];

    vn_extractor #(.DECIM(1), .REP_LIMIT(4), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .raw_bit(raw_bit), .raw_valid(raw_valid), .enable(enable),
        .bit_out(bo0), .bit_valid(bv0), .health_fail(hf0), .emitted_count(cnt0)
    );

    vn_extractor #(.DECIM(2), .REP_LIMIT(6), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .raw_bit(raw_bit), .raw_valid(raw_valid), .enable(enable),
        .bit_out(bo1), .bit_valid(bv1), .health_fail(hf1), .emitted_count(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: count accepted samples, every DECIM-th is used; pairs are taken from the used-sample list.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 0;
            if (reset) begin
                m_nacc[i] = 0; m_run[i] = 0; m_last[i] = 0; m_half[i] = -1;
                m_fail[i] = 0; m_cnt[i] = 0; m_out[i] = 0;
            end else if (!enable) begin
                m_half[i] = -1;
                m_nacc[i] = 0;
            end else if (raw_valid && m_fail[i] == 0) begin
                m_nacc[i]++;
                if (m_nacc[i] % m_decim[i] == 0) begin
                    if (m_run[i] > 0 && int'(raw_bit) == m_last[i]) m_run[i]++;
                    else m_run[i] = 1;
                    m_last[i] = int'(raw_bit);
                    if (m_run[i] == m_lim[i]) m_fail[i] = 1;
                    if (m_half[i] < 0) begin
                        m_half[i] = int'(raw_bit);
                    end else begin
                        if (m_half[i] != int'(raw_bit)) begin
                            m_out[i] = m_half[i];
                            m_vld[i] = 1;
                            if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                        end
                        m_half[i] = -1;
                    end
                    if (m_fail[i] == 1) m_half[i] = -1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("vld0", {31'b0, bv0}, m_vld[0]);
        chk("out0", {31'b0, bo0}, m_out[0]);
        chk("hf0",  {31'b0, hf0}, m_fail[0]);
        chk("cnt0", {16'b0, cnt0}, m_cnt[0]);
        chk("vld1", {31'b0, bv1}, m_vld[1]);
        chk("out1", {31'b0, bo1}, m_out[1]);
        chk("hf1",  {31'b0, hf1}, m_fail[1]);
        chk("cnt1", {29'b0, cnt1}, m_cnt[1]);
    endtask

    task automatic cycle(input logic v, input logic b, input logic e);
        raw_valid = v;
        raw_bit   = b;
        enable    = e;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (bv0) n_strb0++;
        if (bv1) n_strb1++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    int s0, s1;

    initial begin
        reset = 1'b1; raw_valid = 1'b0; raw_bit = 1'b0; enable = 1'b1;
        do_reset();
        chk("rst_vld", {31'b0, bv0}, 0);
        chk("rst_out", {31'b0, bo0}, 0);
        chk("rst_hf",  {31'b0, hf0}, 0);
        chk("rst_cnt", {16'b0, cnt0}, 0);

        // 01 then 10 back to back
        cycle(1, 0, 1); cycle(1, 1, 1);
        chk("p01_vld", {31'b0, bv0}, 1);
        chk("p01_out", {31'b0, bo0}, 0);
        cycle(1, 1, 1);
        chk("gap_vld", {31'b0, bv0}, 0);
        cycle(1, 0, 1);
        chk("p10_vld", {31'b0, bv0}, 1);
        chk("p10_out", {31'b0, bo0}, 1);
        chk("p_cnt",   {16'b0, cnt0}, 2);

        // equal pairs discarded
        do_reset(); s0 = n_strb0;
        cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 1, 1); cycle(1, 1, 1);
        chk("eq_strb", n_strb0 - s0, 0);
        chk("eq_cnt",  {16'b0, cnt0}, 0);
        chk("eq_hf",   {31'b0, hf0}, 0);

        // repetition failure at the 4th identical sample
        do_reset();
        cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 1, 1);
        chk("rep3_hf", {31'b0, hf0}, 0);
        cycle(1, 1, 1);
        chk("rep4_hf", {31'b0, hf0}, 1);
        s0 = n_strb0;
        cycle(1, 0, 1); cycle(1, 1, 1);
        chk("fail_strb", n_strb0 - s0, 0);
        chk("fail_cnt",  {16'b0, cnt0}, 0);
        chk("fail_hf",   {31'b0, hf0}, 1);
        do_reset();
        chk("clr_hf", {31'b0, hf0}, 0);
        cycle(1, 0, 1); cycle(1, 1, 1);
        chk("clr_vld", {31'b0, bv0}, 1);
        chk("clr_out", {31'b0, bo0}, 0);

        // decimation by 2 on dut1: used samples are 1,0
        do_reset(); s1 = n_strb1;
        cycle(1, 0, 1); cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 0, 1);
        chk("dec_vld",  {31'b0, bv1}, 1);
        chk("dec_out",  {31'b0, bo1}, 1);
        chk("dec_strb", n_strb1 - s1, 1);

        // enable low discards the stored half
        do_reset(); s0 = n_strb0;
        cycle(1, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0);
        cycle(1, 1, 1); cycle(1, 0, 1);
        chk("en_out",  {31'b0, bo0}, 1);
        chk("en_strb", n_strb0 - s0, 1);

        // raw_valid gap keeps the half pair
        do_reset();
        cycle(1, 0, 1);
        for (int k = 0; k < 5; k++) cycle(0, 1, 1);
        cycle(1, 1, 1);
        chk("gap_pvld", {31'b0, bv0}, 1);
        chk("gap_pout", {31'b0, bo0}, 0);

        // reset while holding a half pair
        do_reset(); s0 = n_strb0;
        cycle(1, 1, 1);
        do_reset();
        cycle(1, 0, 1); cycle(1, 1, 1);
        chk("rha_out",  {31'b0, bo0}, 0);
        chk("rha_strb", n_strb0 - s0, 1);

        // counter saturation on the 3-bit instance
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(1, 0, 1); cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 0, 1);
        end
        chk("sat_cnt1", {29'b0, cnt1}, 7);
        chk("sat_cnt0", {16'b0, cnt0}, 16);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            reset = (k % 50 == 49);
            cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 15) != 0));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
